// File: rtl/bcd_preset_adjuster.sv
// rtl/bcd_preset_adjuster.sv - N-digit BCD preset value with add/sub stepping, auto-repeat and load strobe
//
// Holds an ADJ_DIGITS-wide BCD value. Each add or sub press changes it by one unit,
// with BCD carry and borrow across digits. The value wraps or clamps at 0 and MAX_VALUE.
// A held button auto-repeats: the first repeat comes REPEAT_DELAY cycles after the first
// step, and later repeats come every REPEAT_PERIOD cycles.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   add       increment request (level)
//   sub       decrement request (level)
//   clr_req   clear value to zero; highest priority after reset
//   out_word  {adjustable BCD digits, ZERO_DIGITS x 4'h0}, MS digit at the top
//   load      one-cycle strobe when out_word takes a new value
//   wrap      one-cycle strobe on a wrap-around step
//   at_max    value == MAX_VALUE
//   at_zero   value == 0
module bcd_preset_adjuster #(
  parameter int ADJ_DIGITS    = 2,
  parameter int ZERO_DIGITS   = 2,
  parameter int MAX_VALUE     = 99,
  parameter int WRAP          = 1,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  add,
  input  logic                                  sub,
  input  logic                                  clr_req,
  output logic [4*(ADJ_DIGITS+ZERO_DIGITS)-1:0] out_word,
  output logic                                  load,
  output logic                                  wrap,
  output logic                                  at_max,
  output logic                                  at_zero
);

  localparam int VW      = 4 * ADJ_DIGITS;
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  function automatic logic [VW-1:0] to_bcd(input int v);
    int r;
    to_bcd = '0;
    r = v;
    for (int i = 0; i < ADJ_DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  localparam logic [VW-1:0] MAX_BCD = to_bcd(MAX_VALUE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEAT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      held_q, held_d;  // {add,sub} pattern being auto-repeated
  logic [VW-1:0]   value_q, value_d;
  logic            load_d, wrap_d;
  logic            do_step;
  logic [VW-1:0]   inc_val, dec_val;
  logic            carry, borrow;
  logic            cmd_valid;

  assign cmd_valid = add ^ sub;

  // Repeat FSM: decides on which cycles a step is applied.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    do_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          do_step = 1'b1;
          cnt_d   = '0;
          held_d  = {add, sub};
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if ({add, sub} != held_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(REPEAT_DELAY - 1)) begin
          do_step = 1'b1;
          cnt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REPEAT: begin
        if ({add, sub} != held_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(REPEAT_PERIOD - 1)) begin
          do_step = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Ripple BCD increment and decrement of the whole multi-digit value.
  always_comb begin
    inc_val = value_q;
    dec_val = value_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < ADJ_DIGITS; i++) begin
      if (carry) begin
        if (value_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (value_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Limit handling uses the full value. A clamped step still counts for the repeat timing.
  // A clamped step changes nothing, so it raises no strobe.
  always_comb begin
    value_d = value_q;
    load_d  = 1'b0;
    wrap_d  = 1'b0;
    if (do_step) begin
      if (add) begin
        if (value_q == MAX_BCD) begin
          if (WRAP != 0) begin
            value_d = '0;
            load_d  = 1'b1;
            wrap_d  = 1'b1;
          end
        end else begin
          value_d = inc_val;
          load_d  = 1'b1;
        end
      end else begin
        if (value_q == '0) begin
          if (WRAP != 0) begin
            value_d = MAX_BCD;
            load_d  = 1'b1;
            wrap_d  = 1'b1;
          end
        end else begin
          value_d = dec_val;
          load_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
      value_q <= '0;
      load    <= 1'b0;
      wrap    <= 1'b0;
    end else if (clr_req) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
      value_q <= '0;
      load    <= 1'b1;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      value_q <= value_d;
      load    <= load_d;
      wrap    <= wrap_d;
    end
  end

  assign at_max  = (value_q == MAX_BCD);
  assign at_zero = (value_q == '0);

  generate
    if (ZERO_DIGITS == 0) begin : g_no_zero
      assign out_word = value_q;
    end else begin : g_zero
      assign out_word = {value_q, {(4*ZERO_DIGITS){1'b0}}};
    end
  endgenerate

endmodule

// File: doc/bcd_preset_adjuster.md
Name: bcd_preset_adjuster

Overview:
- Parametrised successor to the two-digit timer add/sub preset logic.
- Holds an N-digit BCD preset value and adjusts it by one unit per add/sub press.
- Applies full BCD carry/borrow across digits, with wrap or clamp at the limits.
- Auto-repeats while a button is held.
- Emits a fixed-format preset word with forced-zero low digits, plus a one-cycle load strobe for the downstream flip-flop loader.

Parameters:
- ADJ_DIGITS, 2: number of adjustable BCD digits (1..4).
- ZERO_DIGITS, 2: number of low BCD digits forced to 0 in out_word (0..4).
- MAX_VALUE, 99: upper limit of the adjustable field, decimal; must be < 10^ADJ_DIGITS.
- WRAP, 1: 1 = wrap-around at the limits; 0 = clamp at the limits.
- REPEAT_DELAY, 8: cycles from the first step to the first auto-repeat step (>=2).
- REPEAT_PERIOD, 4: cycles between subsequent auto-repeat steps (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- add  in  1  increment request, level; already synchronous to clk.
- sub  in  1  decrement request, level; already synchronous to clk.
- clr_req  in  1  clear value to zero; highest priority.
- out_word  out  4*(ADJ_DIGITS+ZERO_DIGITS)  {adjustable BCD digits, ZERO_DIGITS x 4'h0}; MS digit at the top.
- load  out  1  one-cycle strobe; asserted in the same cycle out_word first shows a new value.
- wrap  out  1  one-cycle strobe on a wrap-around step.
- at_max  out  1  value == MAX_VALUE (combinational from the register).
- at_zero  out  1  value == 0 (combinational from the register).

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates on the rising clk edge.
- Reset state: value 0, FSM in IDLE, repeat counter 0, load 0, wrap 0. Reset overrides everything, including mid-repeat.
- Command decode: cmd is valid when exactly one of add/sub is high. add&sub together is treated as no command.
- FSM states IDLE, WAIT, REPEAT:
  - IDLE + valid cmd: apply one step, counter <= 0, go to WAIT.
  - WAIT: while the same cmd is held, counter increments. When counter == REPEAT_DELAY-1: apply a step, counter <= 0, go to REPEAT.
  - REPEAT: while the same cmd is held, counter increments. When counter == REPEAT_PERIOD-1: apply a step, counter <= 0.
  - WAIT/REPEAT + any change of {add,sub} (release, swap, both high): go to IDLE, no step that cycle. A new valid cmd is serviced from IDLE on the next cycle.
- Step rules:
  - Increment is BCD-correct: a digit at 9 rolls to 0 and carries into the next digit. Decrement is the mirror, with borrow.
  - Increment at MAX_VALUE: WRAP=1 -> value 0, wrap=1, load=1. WRAP=0 -> value unchanged, no load, no wrap.
  - Decrement at 0: WRAP=1 -> value MAX_VALUE, wrap=1, load=1. WRAP=0 -> value unchanged, no load.
  - The limit check uses the full multi-digit value, not the per-digit value.
- clr_req: value <= 0, load=1 (even if already 0), wrap=0, FSM -> IDLE, counter <= 0.
  - clr_req overrides any step in the same cycle.
  - If add/sub is held when clr_req drops, stepping resumes from IDLE.
- Latency: the value register, load and wrap update on the same edge. out_word reflects the new value on the edge after the IDLE cycle that saw the cmd.
- load/wrap: high for exactly one cycle per effective change.
- Digits stay in 0..9 at all times; a non-BCD digit is unreachable.
- Clamp-mode hold: holding at the limit keeps the FSM repeating with no load/wrap strobes.

Test Plan (defaults unless stated):
1. Reset, then add high 1 cycle -> next cycle out_word=16'h0100, load=1 for 1 cycle, wrap=0, at_zero=0.
2. Value 09, add pulse -> out_word=16'h1000 (carry into tens). Then sub pulse -> 16'h0900 (borrow).
3. From 00, hold add 20 cycles -> steps at cycles 0,8,12,16; out_word=16'h0400 after release; exactly 4 load pulses.
4. Value 99, add pulse -> 16'h0000, wrap=1, load=1. Then sub pulse -> 16'h9900, wrap=1. With WRAP=0: add at 99 -> stays 16'h9900, no load, at_max=1.
5. add&sub high together 10 cycles -> no change, no load. Swap add->sub while held -> one IDLE cycle, then a decrement step.
6. Reset asserted during REPEAT with add held -> out_word=16'h0000, load=0 during reset; first increment one cycle after reset drops. clr_req with simultaneous add -> 16'h0000, load=1, no increment.
